// File: rtl/ps2_host_tx_if.sv
// Host-side command handshake plus the open-drain PS/2 pin pair for the PS/2 transmitter.
// The slave modport is the transmitter; the master modport is the surrounding system/bus.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       done;
  logic       err;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  modport slave (
    input  tx_data, tx_start, ps2_clk, ps2_data,
    output tx_busy, done, err, ps2_clk_oe, ps2_data_oe
  );

  modport master (
    output tx_data, tx_start, ps2_clk, ps2_data,
    input  tx_busy, done, err, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, clocks out a byte
// on device-generated falling edges and checks the device ACK.
module ps2_host_tx #(
  parameter int LEN            = 8,
  parameter int INHIBIT_CYCLES = 3000,
  parameter int REQ_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic          clk,
  input  logic          reset,
  ps2_host_tx_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

  state_t       state_q, state_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [3:0]   bitcnt_q, bitcnt_d;
  logic [7:0]   shreg_q, shreg_d;
  logic         parity_q, parity_d;
  logic         clkOe_q, clkOe_d;
  logic         dataOe_q, dataOe_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic [1:0]   clkSync_q, dataSync_q;
  logic [LEN:0] clkSamp_q;
  logic         filt_q, filt_d;
  logic         allOnes, allZero, fall, dataIn;

  assign allOnes = &clkSamp_q;
  assign allZero = ~|clkSamp_q;
  assign fall    = filt_q & allZero;
  assign dataIn  = dataSync_q[1];

  // Filter is forced low while we hold the clock line ourselves, so release cannot fake a fall.
  always_comb begin
    filt_d = filt_q;
    if (state_q == INHIBIT || state_q == REQ) filt_d = 1'b0;
    else if (allOnes)                         filt_d = 1'b1;
    else if (allZero)                         filt_d = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;
    clkOe_d  = clkOe_q;
    dataOe_d = dataOe_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d   = 1'b0;
        clkOe_d  = 1'b0;
        dataOe_d = 1'b0;
        if (bus.tx_start && !busy_q) begin
          shreg_d  = bus.tx_data;
          parity_d = ~^bus.tx_data;
          cnt_d    = '0;
          clkOe_d  = 1'b1;
          busy_d   = 1'b1;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == 32'(INHIBIT_CYCLES - 1)) begin
          cnt_d    = '0;
          dataOe_d = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == 32'(REQ_CYCLES - 1)) begin
          cnt_d    = '0;
          bitcnt_d = '0;
          clkOe_d  = 1'b0;
          state_d  = SEND;
        end
      end
      SEND, ACK, WAIT_IDLE: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          err_d    = 1'b1;
          clkOe_d  = 1'b0;
          dataOe_d = 1'b0;
          state_d  = IDLE;
        end else if (state_q == SEND) begin
          if (fall) begin
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q < 4'd8) begin
              dataOe_d = ~shreg_q[0];
              shreg_d  = shreg_q >> 1;
            end else if (bitcnt_q == 4'd8) begin
              dataOe_d = ~parity_q;
            end else begin
              dataOe_d = 1'b0;
              state_d  = ACK;
            end
          end
        end else if (state_q == ACK) begin
          if (fall) begin
            if (!dataIn) state_d = WAIT_IDLE;
            else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end else if (filt_q && dataIn) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      clkOe_q    <= 1'b0;
      dataOe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      clkSync_q  <= '0;
      dataSync_q <= '0;
      clkSamp_q  <= '0;
      filt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      parity_q   <= parity_d;
      clkOe_q    <= clkOe_d;
      dataOe_q   <= dataOe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      clkSync_q  <= {clkSync_q[0], bus.ps2_clk};
      dataSync_q <= {dataSync_q[0], bus.ps2_data};
      clkSamp_q  <= {clkSamp_q[LEN-1:0], clkSync_q[1]};
      filt_q     <= filt_d;
    end
  end

  assign bus.tx_busy     = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.ps2_clk_oe  = clkOe_q;
  assign bus.ps2_data_oe = dataOe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: an open-drain PS/2 device model clocks frames out of
// the transmitter and compares captured bits against a byte-level frame model.
module tb_ps2_host_tx;
  localparam int INH = 3000;
  localparam int RQ  = 50;
  localparam int TO  = 4000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic devClk = 1'b1;
  logic devData = 1'b1;
  int   checkCount = 0;
  int   passCount = 0;

  int   doneTotal = 0;
  int   errTotal = 0;
  int   bothTotal = 0;
  logic [1:0] oeAtErr = 2'b11;
  logic busyAfterPulse = 1'b1;
  logic pulsePrev = 1'b0;

  ps2_host_tx_if bus ();

  assign bus.ps2_clk  = devClk & ~bus.ps2_clk_oe;
  assign bus.ps2_data = devData & ~bus.ps2_data_oe;

  ps2_host_tx #(.LEN(8), .INHIBIT_CYCLES(INH), .REQ_CYCLES(RQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Pulse monitor: tallies done/err and records what the lines looked like around each pulse.
  always @(negedge clk) begin
    pulsePrev <= bus.done | bus.err;
    if (pulsePrev) busyAfterPulse <= bus.tx_busy;
    if (bus.done) doneTotal <= doneTotal + 1;
    if (bus.err) begin
      errTotal <= errTotal + 1;
      oeAtErr  <= {bus.ps2_clk_oe, bus.ps2_data_oe};
    end
    if (bus.done && bus.err) bothTotal <= bothTotal + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected 11 line values seen by the device: start, d0..d7, odd parity, stop.
  function automatic logic [10:0] frameModel(input logic [7:0] d);
    int ones = 0;
    logic [10:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      ones += int'((d >> i) & 8'd1);
      m[i+1] = d[i];
    end
    m[0]  = 1'b0;
    m[9]  = (ones % 2 == 0);
    m[10] = 1'b1;
    return m;
  endfunction

  task automatic applyStimulus(input logic [7:0] data);
    @(negedge clk);
    bus.tx_data  = data;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    bus.tx_data  = ~data;
    checkOutput("busyAfterAccept", {31'd0, bus.tx_busy}, 32'd1);
  endtask

  task automatic deviceFrame(input bit ack, input int glitchAt, input int resetAt, input int injectAt,
                             output logic [10:0] bits, output int inhCnt, output int reqCnt,
                             output bit released);
    bits = '0; inhCnt = 0; reqCnt = 0; released = 1'b0;
    for (int i = 0; i < 10000 && !released; i++) begin
      if (bus.ps2_clk_oe && !bus.ps2_data_oe) inhCnt++;
      else if (bus.ps2_clk_oe && bus.ps2_data_oe) reqCnt++;
      else released = 1'b1;
      if (!released) @(negedge clk);
    end
    if (!released) return;
    repeat (40) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      bits[k-1] = bus.ps2_data;
      if (k == 11 && ack) begin
        devData = 1'b0;
        repeat (5) @(negedge clk);
      end
      devClk = 1'b0;
      if (k == resetAt) begin
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("resetMidFrame", {29'd0, bus.ps2_clk_oe, bus.ps2_data_oe, bus.tx_busy}, 32'd0);
        devClk = 1'b1;
        return;
      end
      if (k == injectAt) begin
        bus.tx_data  = 8'h55;
        bus.tx_start = 1'b1;
      end
      repeat (30) @(negedge clk);
      bus.tx_start = 1'b0;
      devClk = 1'b1;
      if (k == 11) devData = 1'b1;
      if (k == glitchAt) begin
        repeat (10) @(negedge clk);
        devClk = 1'b0;
        repeat (5) @(negedge clk);
        devClk = 1'b1;
        repeat (15) @(negedge clk);
      end else begin
        repeat (30) @(negedge clk);
      end
    end
  endtask

  task automatic runFrame(input logic [7:0] data, input bit ack, input int glitchAt, input int injectAt);
    logic [10:0] bits;
    int inhCnt, reqCnt, d0, e0;
    bit released;
    d0 = doneTotal;
    e0 = errTotal;
    applyStimulus(data);
    deviceFrame(ack, glitchAt, 0, injectAt, bits, inhCnt, reqCnt, released);
    checkOutput("released", {31'd0, released}, 32'd1);
    checkOutput("inhibitCycles", inhCnt, INH);
    checkOutput("reqCycles", reqCnt, RQ);
    repeat (20) @(negedge clk);
    checkOutput("frameBits", {21'd0, bits}, {21'd0, frameModel(data)});
    checkOutput("doneCount", doneTotal - d0, ack ? 1 : 0);
    checkOutput("errCount", errTotal - e0, ack ? 0 : 1);
    if (!ack) begin
      checkOutput("oeAtErr", {30'd0, oeAtErr}, 32'd0);
      checkOutput("busyAfterErr", {31'd0, busyAfterPulse}, 32'd0);
    end
    checkOutput("busyIdle", {31'd0, bus.tx_busy}, 32'd0);
  endtask

  initial begin
    logic [10:0] bits;
    int inhCnt, reqCnt, n, d0, e0;
    bit released;
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("resetState",
                {27'd0, bus.ps2_clk_oe, bus.ps2_data_oe, bus.tx_busy, bus.done, bus.err}, 32'd0);
    repeat (20) @(negedge clk);

    $display("[TB] normal frame and parity cases");
    runFrame(8'hED, 1'b1, 0, 0);
    runFrame(8'h01, 1'b1, 0, 0);
    runFrame(8'h00, 1'b1, 0, 0);
    runFrame(8'hFF, 1'b1, 0, 0);

    $display("[TB] missing ACK");
    runFrame(8'hA5, 1'b0, 0, 0);

    $display("[TB] device never clocks");
    e0 = errTotal;
    applyStimulus(8'h3C);
    n = 0;
    while (bus.ps2_clk_oe && n < 10000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("toRelease", {31'd0, bus.ps2_clk_oe}, 32'd0);
    n = 0;
    while (!bus.err && n < 2 * TO) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeoutCycles", n, TO);
    checkOutput("timeoutOe", {30'd0, bus.ps2_clk_oe, bus.ps2_data_oe}, 32'd0);
    @(negedge clk);
    checkOutput("timeoutBusy", {31'd0, bus.tx_busy}, 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("timeoutErrCount", errTotal - e0, 1);

    $display("[TB] second request mid-frame ignored");
    runFrame(8'hED, 1'b1, 0, 3);

    $display("[TB] reset mid-frame");
    d0 = doneTotal;
    e0 = errTotal;
    applyStimulus(8'h96);
    deviceFrame(1'b1, 0, 5, 0, bits, inhCnt, reqCnt, released);
    repeat (50) @(negedge clk);
    checkOutput("resetNoPulses", (doneTotal - d0) + (errTotal - e0), 0);
    checkOutput("resetBusy", {31'd0, bus.tx_busy}, 32'd0);

    $display("[TB] short clock glitch");
    runFrame(8'hC3, 1'b1, 4, 0);

    $display("[TB] randomized frames");
    for (int r = 0; r < 3; r++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      runFrame(d, 1'b1, int'($urandom_range(0, 10)), 0);
    end

    checkOutput("neverBoth", bothTotal, 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
